// File: rtl/mem_lane_steer.sv
// mem_lane_steer: registered steering stage between decode and the per-lane
// execute units. Each accepted bundle is split into issue groups that hold at
// most one memory op, and that op is always moved onto the load/store lane.
// A slot that is not valid in an issued group is driven as all zeros.
module mem_lane_steer #(
    parameter int LANES    = 4,
    parameter int MEM_LANE = 3,
    parameter int DES      = 4,
    parameter int SRC1     = 4,
    parameter int SRC2     = 4,
    parameter int BR_ID    = 3,
    parameter int IMM      = 5,
    parameter int CNT_W    = 16,
    localparam int IW      = 1 + DES + SRC1 + SRC2 + 4 + BR_ID + IMM
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [LANES*IW-1:0] in_bundle,
    input  logic [LANES-1:0]    in_mem,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [LANES*IW-1:0] out_bundle,
    output logic                out_last,
    output logic [CNT_W-1:0]    split_cnt
);

    logic [LANES*IW-1:0] slot_buf;
    logic [LANES-1:0]    pend;
    logic [LANES-1:0]    mem_q;

    logic [LANES-1:0]    in_slot_vld;
    logic [LANES-1:0]    grp;
    logic                has_mem;
    int                  mem_idx;
    logic [LANES*IW-1:0] steer;
    logic                load;
    logic                empties;
    logic                accept;
    logic                multi_mem;

    // Pull the valid bit (slot MSB) out of every incoming slot
    always_comb begin
        in_slot_vld = '0;
        for (int i = 0; i < LANES; i++) begin
            in_slot_vld[i] = in_bundle[i*IW + IW - 1];
        end
    end

    // Form the next group: pending slots from the lowest index upward,
    // stopping just before a second pending memory op
    always_comb begin
        grp     = '0;
        has_mem = 1'b0;
        mem_idx = 0;
        for (int i = 0; i < LANES; i++) begin
            if (pend[i] && !(mem_q[i] && has_mem) && !(grp == '0 && i > 0 && pend[i-1])) begin
                grp[i] = 1'b1;
                if (mem_q[i]) begin
                    has_mem = 1'b1;
                    mem_idx = i;
                end
            end else if (pend[i] && mem_q[i] && has_mem) begin
                break;
            end
        end
    end

    // Build the steered group: pass group slots through, then move the memory
    // op onto the load/store lane and swap or invalidate its old position
    always_comb begin
        steer = '0;
        for (int i = 0; i < LANES; i++) begin
            if (grp[i]) begin
                steer[i*IW +: IW] = slot_buf[i*IW +: IW];
            end
        end
        if (has_mem && mem_idx != MEM_LANE) begin
            steer[MEM_LANE*IW +: IW] = slot_buf[mem_idx*IW +: IW];
            if (grp[MEM_LANE]) begin
                steer[mem_idx*IW +: IW] = slot_buf[MEM_LANE*IW +: IW];
            end else begin
                steer[mem_idx*IW +: IW] = '0;
            end
        end
    end

    // Handshake decisions: load a group when the output slot is free, accept a
    // new bundle once the current one is fully drained (or drains this cycle)
    always_comb begin
        load      = (pend != '0) && (!out_vld || out_rdy);
        empties   = (grp == pend);
        in_rdy    = (pend == '0) || (empties && load);
        accept    = in_vld && in_rdy;
        multi_mem = $countones(in_mem & in_slot_vld) >= 2;
    end

    // Bundle buffer and pending mask: retire the issued group, and a newly
    // accepted bundle overwrites whatever is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_buf <= '0;
            pend     <= '0;
            mem_q    <= '0;
        end else begin
            if (load) begin
                pend <= pend & ~grp;
            end
            if (accept) begin
                slot_buf <= in_bundle;
                pend     <= in_slot_vld;
                mem_q    <= in_mem & in_slot_vld;
            end
        end
    end

    // Output register: load a fresh group, or drop valid once it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_bundle <= '0;
            out_last   <= 1'b0;
        end else if (load) begin
            out_vld    <= 1'b1;
            out_bundle <= steer;
            out_last   <= empties;
        end else if (out_rdy) begin
            out_vld    <= 1'b0;
        end
    end

    // Saturating count of accepted bundles that need more than one group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (accept && multi_mem && split_cnt != '1) begin
            split_cnt <= split_cnt + 1'b1;
        end
    end

endmodule
